// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a Uart8 transmitter: accepts one byte,
// launches the frame, waits for busy/done, and abandons frames that stall.
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 65535  // legal range 2..65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       txEn,
   output logic       txStart,
   output logic [7:0] txIn,
   input  logic       txBusy,
   input  logic       txDone,
   output logic       sent,
   output logic       sentId,
   output logic       timeoutErr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_tx_in;
   logic        r_cur_id;
   logic        r_last_grant;
   logic        r_timeout_err;
   logic [15:0] r_cnt;

   logic        w_grant0;
   logic        w_grant1;
   logic        w_transfer;
   logic        w_timeout;
   logic        w_cnt_last;

   // Only IDLE grants; on contention the requester that did not go last wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (r_state == S_IDLE && en && !reset) begin
         if (req0_valid && (!req1_valid || r_last_grant)) begin
            w_grant0 = 1'b1;
         end else if (req1_valid) begin
            w_grant1 = 1'b1;
         end
      end
   end

   assign w_transfer = w_grant0 | w_grant1;
   assign w_cnt_last = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples the pre-edge values of the others.
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Done is checked before busy and before the timeout: a completion always
   // beats both the START->SEND hop and an expiring counter on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_transfer) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (txDone) begin
               w_state_nxt = S_DONE;
            end else if (txBusy) begin
               w_state_nxt = S_SEND;
            end else if (w_cnt_last) begin
               w_state_nxt = S_IDLE;
               w_timeout   = 1'b1;
            end
         end
         S_SEND: begin
            if (txDone) begin
               w_state_nxt = S_DONE;
            end else if (w_cnt_last) begin
               w_state_nxt = S_IDLE;
               w_timeout   = 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_in       <= 8'h00;
         r_cur_id      <= 1'b0;
         r_last_grant  <= 1'b1;
         r_cnt         <= 16'd0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         if (w_transfer) begin
            r_tx_in  <= w_grant1 ? req1_data : req0_data;
            r_cur_id <= w_grant1;
            r_cnt    <= 16'd0;
         end else if (r_state == S_START || r_state == S_SEND) begin
            r_cnt <= r_cnt + 16'd1;
         end else begin
            r_cnt <= 16'd0;
         end
         // An abandoned frame still counts as that requester's turn.
         if (r_state == S_DONE || w_timeout) begin
            r_last_grant <= r_cur_id;
         end
      end
   end

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign txStart    = (r_state == S_START);
   assign txEn       = en | (r_state != S_IDLE);
   assign txIn       = r_tx_in;
   assign sent       = (r_state == S_DONE);
   assign sentId     = (r_state == S_DONE) & r_cur_id;
   assign timeoutErr = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the Uart8 side is driven by hand, cycle by
// cycle, and every output is compared against hand-computed values.
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       txEn;
   logic       txStart;
   logic [7:0] txIn;
   logic       txBusy;
   logic       txDone;
   logic       sent;
   logic       sentId;
   logic       timeoutErr;

   int n_vec    = 0;
   int n_err    = 0;
   int sent_cnt = 0;

   uart_tx_arbiter #(.TIMEOUT_CYCLES(20)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .txEn       (txEn),
      .txStart    (txStart),
      .txIn       (txIn),
      .txBusy     (txBusy),
      .txDone     (txDone),
      .sent       (sent),
      .sentId     (sentId),
      .timeoutErr (timeoutErr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sent === 1'b1) sent_cnt++;
   end

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; txBusy = 1'b0; txDone = 1'b0;
      req0_valid = 1'b1; req0_data = 8'hAA;
      req1_valid = 1'b1; req1_data = 8'h55;
      #1;
      n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0 got %b want 0", req0_ready); end
      n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1 got %b want 0", req1_ready); end
      n_vec++; if (txStart !== 1'b0) begin n_err++; $display("FAIL rst_txStart got %b want 0", txStart); end
      n_vec++; if (txIn !== 8'h00) begin n_err++; $display("FAIL rst_txIn got %h want 00", txIn); end
      n_vec++; if (sent !== 1'b0) begin n_err++; $display("FAIL rst_sent got %b want 0", sent); end
      n_vec++; if (sentId !== 1'b0) begin n_err++; $display("FAIL rst_sentId got %b want 0", sentId); end
      n_vec++; if (timeoutErr !== 1'b0) begin n_err++; $display("FAIL rst_timeoutErr got %b want 0", timeoutErr); end
      tick(); tick();
      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      n_vec++; if (txEn !== 1'b1) begin n_err++; $display("FAIL rst_txEn_idle got %b want 1", txEn); end
   endtask

   task automatic test_single();
      int sc;
      tick();
      sc = sent_cnt;
      req0_valid = 1'b1; req0_data = 8'h7A;
      #1;
      n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0 got %b want 1", req0_ready); end
      n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1 got %b want 0", req1_ready); end
      tick(); req0_valid = 1'b0; #1;
      n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL single_ready0_drop got %b want 0", req0_ready); end
      n_vec++; if (txStart !== 1'b1) begin n_err++; $display("FAIL single_start_k1 got %b want 1", txStart); end
      n_vec++; if (txIn !== 8'h7A) begin n_err++; $display("FAIL single_txIn got %h want 7a", txIn); end
      tick(); txBusy = 1'b1; #1;
      n_vec++; if (txStart !== 1'b1) begin n_err++; $display("FAIL single_start_hold got %b want 1", txStart); end
      tick(); #1;
      n_vec++; if (txStart !== 1'b0) begin n_err++; $display("FAIL single_start_after_busy got %b want 0", txStart); end
      n_vec++; if (txIn !== 8'h7A) begin n_err++; $display("FAIL single_txIn_send got %h want 7a", txIn); end
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         n_vec++; if (sent !== 1'b0) begin n_err++; $display("FAIL single_sent_early cyc %0d got %b want 0", i, sent); end
      end
      tick(); txBusy = 1'b0; txDone = 1'b1; #1;
      n_vec++; if (sent !== 1'b0) begin n_err++; $display("FAIL single_sent_pre got %b want 0", sent); end
      tick(); txDone = 1'b0; #1;
      n_vec++; if (sent !== 1'b1) begin n_err++; $display("FAIL single_sent got %b want 1", sent); end
      n_vec++; if (sentId !== 1'b0) begin n_err++; $display("FAIL single_sentId got %b want 0", sentId); end
      n_vec++; if (txIn !== 8'h7A) begin n_err++; $display("FAIL single_txIn_done got %h want 7a", txIn); end
      tick(); #1;
      n_vec++; if (sent !== 1'b0) begin n_err++; $display("FAIL single_sent_clear got %b want 0", sent); end
      n_vec++; if (txStart !== 1'b0) begin n_err++; $display("FAIL single_idle_start got %b want 0", txStart); end
      n_vec++; if (sent_cnt !== sc + 1) begin n_err++; $display("FAIL single_sent_count got %0d want %0d", sent_cnt, sc + 1); end
   endtask

   task automatic test_round_robin();
      logic       exp_id;
      logic [7:0] exp_data;
      tick(); reset = 1'b1; #1;
      tick(); reset = 1'b0;
      req0_valid = 1'b1; req0_data = 8'hB1;
      req1_valid = 1'b1; req1_data = 8'h55;
      #1;
      for (int f = 0; f < 4; f++) begin
         exp_id   = f[0];
         exp_data = exp_id ? 8'h55 : 8'hB1;
         n_vec++; if (req0_ready !== ~exp_id) begin n_err++; $display("FAIL rr_ready0 frame %0d got %b want %b", f, req0_ready, ~exp_id); end
         n_vec++; if (req1_ready !== exp_id) begin n_err++; $display("FAIL rr_ready1 frame %0d got %b want %b", f, req1_ready, exp_id); end
         tick(); txBusy = 1'b1; #1;
         n_vec++; if (txIn !== exp_data) begin n_err++; $display("FAIL rr_txIn frame %0d got %h want %h", f, txIn, exp_data); end
         n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rr_ready_busy frame %0d got %b want 00", f, {req0_ready, req1_ready}); end
         tick(); txBusy = 1'b0; txDone = 1'b1; #1;
         n_vec++; if (txStart !== 1'b0) begin n_err++; $display("FAIL rr_send_start frame %0d got %b want 0", f, txStart); end
         tick(); txDone = 1'b0; #1;
         n_vec++; if (sent !== 1'b1) begin n_err++; $display("FAIL rr_sent frame %0d got %b want 1", f, sent); end
         n_vec++; if (sentId !== exp_id) begin n_err++; $display("FAIL rr_sentId frame %0d got %b want %b", f, sentId, exp_id); end
         tick();
         if (f == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         #1;
      end
   endtask

   task automatic test_timeout();
      int sc;
      sc = sent_cnt;
      req0_valid = 1'b1; req0_data = 8'h3C;
      #1;
      n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL to_ready0 got %b want 1", req0_ready); end
      for (int j = 1; j <= 20; j++) begin
         tick();
         if (j == 1) req0_valid = 1'b0;
         if (j == 20) begin req0_valid = 1'b1; req0_data = 8'hC3; end
         #1;
         n_vec++; if ({txStart, timeoutErr} !== 2'b10) begin n_err++; $display("FAIL to_wait cyc %0d start/err got %b want 10", j, {txStart, timeoutErr}); end
      end
      tick(); #1;
      n_vec++; if (timeoutErr !== 1'b1) begin n_err++; $display("FAIL to_pulse got %b want 1", timeoutErr); end
      n_vec++; if (txStart !== 1'b0) begin n_err++; $display("FAIL to_start_drop got %b want 0", txStart); end
      n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL to_next_accept got %b want 1", req0_ready); end
      n_vec++; if (sent_cnt !== sc) begin n_err++; $display("FAIL to_no_sent got %0d want %0d", sent_cnt, sc); end
      // Second frame: done arrives on the very edge where the timeout would fire.
      for (int j = 1; j <= 20; j++) begin
         tick();
         if (j == 1) req0_valid = 1'b0;
         if (j == 20) txDone = 1'b1;
         #1;
         n_vec++; if ({txStart, timeoutErr} !== 2'b10) begin n_err++; $display("FAIL to2_wait cyc %0d start/err got %b want 10", j, {txStart, timeoutErr}); end
      end
      n_vec++; if (txIn !== 8'hC3) begin n_err++; $display("FAIL to2_txIn got %h want c3", txIn); end
      tick(); txDone = 1'b0; #1;
      n_vec++; if (sent !== 1'b1) begin n_err++; $display("FAIL to2_exit_wins_sent got %b want 1", sent); end
      n_vec++; if (timeoutErr !== 1'b0) begin n_err++; $display("FAIL to2_exit_wins_err got %b want 0", timeoutErr); end
      n_vec++; if (sentId !== 1'b0) begin n_err++; $display("FAIL to2_sentId got %b want 0", sentId); end
      tick(); #1;
      n_vec++; if ({sent, txStart, timeoutErr} !== 3'b000) begin n_err++; $display("FAIL to2_idle got %b want 000", {sent, txStart, timeoutErr}); end
   endtask

   task automatic test_en_drop();
      req1_valid = 1'b1; req1_data = 8'h96;
      #1;
      n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL en_grant got %b want 01", {req0_ready, req1_ready}); end
      tick(); txBusy = 1'b1; #1;
      n_vec++; if (txIn !== 8'h96) begin n_err++; $display("FAIL en_txIn got %h want 96", txIn); end
      n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL en_held_valid got %b want 0", req1_ready); end
      tick(); en = 1'b0; #1;
      n_vec++; if ({txEn, txStart} !== 2'b10) begin n_err++; $display("FAIL en_send_txEn/start got %b want 10", {txEn, txStart}); end
      tick(); txBusy = 1'b0; txDone = 1'b1; #1;
      n_vec++; if (txEn !== 1'b1) begin n_err++; $display("FAIL en_send2_txEn got %b want 1", txEn); end
      tick(); txDone = 1'b0; #1;
      n_vec++; if ({sent, sentId, txEn} !== 3'b111) begin n_err++; $display("FAIL en_done sent/id/txEn got %b want 111", {sent, sentId, txEn}); end
      tick(); #1;
      n_vec++; if ({txEn, req1_ready} !== 2'b00) begin n_err++; $display("FAIL en_idle txEn/ready got %b want 00", {txEn, req1_ready}); end
      tick(); #1;
      n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL en_idle2_ready got %b want 0", req1_ready); end
      req1_valid = 1'b0; en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int sc;
      sc = sent_cnt;
      req0_valid = 1'b1; req0_data = 8'h11;
      #1;
      n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready0 got %b want 1", req0_ready); end
      tick(); req0_valid = 1'b0; #1;
      n_vec++; if (txStart !== 1'b1) begin n_err++; $display("FAIL rm_start got %b want 1", txStart); end
      reset = 1'b1; #1;
      n_vec++; if ({txStart, txIn} !== 9'h000) begin n_err++; $display("FAIL rm_start_abort start/txIn got %h want 000", {txStart, txIn}); end
      tick(); reset = 1'b0; req0_valid = 1'b1; req0_data = 8'h22; #1;
      n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready0_b got %b want 1", req0_ready); end
      tick(); req0_valid = 1'b0; txBusy = 1'b1; #1;
      n_vec++; if (txIn !== 8'h22) begin n_err++; $display("FAIL rm_txIn_b got %h want 22", txIn); end
      tick(); #1;
      n_vec++; if (txStart !== 1'b0) begin n_err++; $display("FAIL rm_in_send got %b want 0", txStart); end
      reset = 1'b1; #1;
      n_vec++; if (txIn !== 8'h00) begin n_err++; $display("FAIL rm_send_txIn got %h want 00", txIn); end
      n_vec++; if ({txStart, sent, sentId, timeoutErr, req0_ready, req1_ready} !== 6'b0) begin n_err++; $display("FAIL rm_send_outs got %b want 000000", {txStart, sent, sentId, timeoutErr, req0_ready, req1_ready}); end
      txBusy = 1'b0;
      tick(); reset = 1'b0; req1_valid = 1'b1; req1_data = 8'hE7; #1;
      n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL rm_req1 got %b want 01", {req0_ready, req1_ready}); end
      tick(); req1_valid = 1'b0; txDone = 1'b1; #1;
      n_vec++; if ({txStart, txIn} !== {1'b1, 8'hE7}) begin n_err++; $display("FAIL rm_req1_start got %h want 1e7", {txStart, txIn}); end
      tick(); txDone = 1'b0; #1;
      n_vec++; if ({sent, sentId} !== 2'b11) begin n_err++; $display("FAIL rm_done_in_start got %b want 11", {sent, sentId}); end
      tick(); #1;
      n_vec++; if (sent_cnt !== sc + 1) begin n_err++; $display("FAIL rm_sent_count got %0d want %0d", sent_cnt, sc + 1); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_en_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
